// File: rtl/move_objeto_pkg.sv
// move_objeto_pkg: shared FSM encoding, monitor bounds, key-vector bit order and clamp helpers
package move_objeto_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, SETTLE_A = 2'd2, SETTLE_B = 2'd3} state_t;
    localparam int MON_W   = 640;
    localparam int MON_H   = 480;
    localparam int K_RIGHT = 0;
    localparam int K_LEFT  = 1;
    localparam int K_DOWN  = 2;
    localparam int K_UP    = 3;
    function automatic logic [10:0] step_up(input logic [10:0] pos, input logic [10:0] step, input logic [10:0] lim);
        return (pos + step > lim) ? lim : pos + step;
    endfunction
    function automatic logic [10:0] step_dn(input logic [10:0] pos, input logic [10:0] step);
        return (pos > step) ? pos - step : 11'd0;
    endfunction
endpackage

// File: rtl/move_objeto_if.sv
// move_if: key levels and collision flags in, object position and step state out
interface move_if;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       colisao_max_x;
    logic       colisao_min_x;
    logic       colisao_max_y;
    logic       colisao_min_y;
    logic [6:0] tamanho;
    logic [9:0] xPos;
    logic [8:0] yPos;
    logic [2:0] step_size;
    logic       moving;
    modport master (
        output key_up, key_down, key_left, key_right,
        output colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y, tamanho,
        input  xPos, yPos, step_size, moving
    );
    modport slave (
        input  key_up, key_down, key_left, key_right,
        input  colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y, tamanho,
        output xPos, yPos, step_size, moving
    );
endinterface

// File: rtl/move_objeto_tick_divisor.sv
// tick_divisor: free-running 0..CLK_DIV-1 prescaler, tick high on the terminal count
module tick_divisor #(
    parameter int CLK_DIV = 416667
) (
    input  logic VGA_clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] r_cnt;
    assign tick = r_cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge VGA_clk or negedge rst_n)
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= tick ? '0 : r_cnt + CW'(1);
endmodule

// File: rtl/move_objeto.sv
// move_objeto: arrow-key position controller, one move per tick, accelerates while the key set is held
module move_objeto
    import move_objeto_pkg::*;
#(
    parameter int CLK_DIV    = 416667,
    parameter int STEP_MIN   = 1,
    parameter int STEP_MAX   = 4,
    parameter int HOLD_TICKS = 30,
    parameter int X_INIT     = 320,
    parameter int Y_INIT     = 240,
    parameter int X_MAX      = MON_W,
    parameter int Y_MAX      = MON_H
) (
    input logic   VGA_clk,
    input logic   rst_n,
    move_if.slave bus
);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    state_t        r_state;
    logic [9:0]    r_x;
    logic [8:0]    r_y;
    logic [2:0]    r_step;
    logic          r_moving;
    logic [HW-1:0] r_hold;
    logic [3:0]    r_last;
    logic          w_tick;
    logic [3:0]    w_keys;
    logic          w_go_r, w_go_l, w_go_d, w_go_u, w_same, w_hold_done;
    logic [10:0]   w_step;
    logic [9:0]    w_x;
    logic [8:0]    w_y;
    logic [2:0]    w_step_inc;
    tick_divisor #(.CLK_DIV(CLK_DIV)) u_div (.VGA_clk(VGA_clk), .rst_n(rst_n), .tick(w_tick));
    assign w_keys      = {bus.key_up, bus.key_down, bus.key_left, bus.key_right};
    assign w_step      = 11'(r_step);
    assign w_go_r      = w_keys[K_RIGHT] & ~w_keys[K_LEFT] & ~bus.colisao_max_x;
    assign w_go_l      = w_keys[K_LEFT] & ~w_keys[K_RIGHT] & ~bus.colisao_min_x;
    assign w_go_d      = w_keys[K_DOWN] & ~w_keys[K_UP] & ~bus.colisao_max_y;
    assign w_go_u      = w_keys[K_UP] & ~w_keys[K_DOWN] & ~bus.colisao_min_y;
    // Clamp in 11 bits first so neither edge can wrap, then narrow to the output width
    assign w_x = w_go_r ? 10'(step_up(11'(r_x), w_step, 11'(X_MAX) - 11'(bus.tamanho)))
               : w_go_l ? 10'(step_dn(11'(r_x), w_step)) : r_x;
    assign w_y = w_go_d ? 9'(step_up(11'(r_y), w_step, 11'(Y_MAX) - 11'(bus.tamanho)))
               : w_go_u ? 9'(step_dn(11'(r_y), w_step)) : r_y;
    assign w_same      = w_keys == r_last;
    assign w_hold_done = r_hold == HW'(HOLD_TICKS - 1);
    assign w_step_inc  = (r_step >= 3'(STEP_MAX)) ? r_step : r_step + 3'd1;
    always_ff @(posedge VGA_clk or negedge rst_n)
        if (!rst_n) begin
            r_state  <= IDLE;
            r_x      <= 10'(X_INIT);
            r_y      <= 9'(Y_INIT);
            r_step   <= 3'(STEP_MIN);
            r_moving <= 1'b0;
            r_hold   <= '0;
            r_last   <= '0;
        end else
            case (r_state)
                IDLE:
                    if (w_tick && |w_keys) r_state <= MOVE;
                    else if (w_tick) begin
                        r_moving <= 1'b0;
                        r_step   <= 3'(STEP_MIN);
                        r_hold   <= '0;
                        r_last   <= '0;
                    end
                MOVE: begin
                    r_x      <= w_x;
                    r_y      <= w_y;
                    r_moving <= (w_x != r_x) || (w_y != r_y);
                    r_last   <= w_keys;
                    r_hold   <= (!w_same || w_hold_done) ? '0 : r_hold + HW'(1);
                    r_step   <= !w_same ? 3'(STEP_MIN) : w_hold_done ? w_step_inc : r_step;
                    r_state  <= SETTLE_A;
                end
                // Two idle cycles give the negedge-registered collision checker time to see the new position
                SETTLE_A: r_state <= SETTLE_B;
                default:  r_state <= IDLE;
            endcase
    assign bus.xPos      = r_x;
    assign bus.yPos      = r_y;
    assign bus.step_size = r_step;
    assign bus.moving    = r_moving;
endmodule
